// File: rtl/roce_ack_responder.sv
// RoCE RC responder ACK/NAK generator: classifies RX BTH PSNs, schedules ACK/NAK into a
// one-entry pending slot, and drives a registered TX BTH/AETH handshake. Stats: ROCE_ACK_STATS_EN.
module roce_ack_responder #(
    parameter int COALESCE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_roce_rx_bth_valid,
    input  logic [7:0]            s_roce_rx_bth_op_code,
    input  logic [23:0]           s_roce_rx_bth_psn,
    input  logic [23:0]           s_roce_rx_bth_dest_qp,
    input  logic                  s_roce_rx_bth_ack_req,
    output logic                  m_roce_tx_bth_valid,
    input  logic                  m_roce_tx_bth_ready,
    output logic [7:0]            m_roce_tx_bth_op_code,
    output logic [15:0]           m_roce_tx_bth_p_key,
    output logic [23:0]           m_roce_tx_bth_psn,
    output logic [23:0]           m_roce_tx_bth_dest_qp,
    output logic                  m_roce_tx_bth_ack_req,
    output logic [7:0]            m_roce_tx_aeth_syndrome,
    output logic [23:0]           m_roce_tx_aeth_msn,
    input  logic [23:0]           monitor_loc_qpn,
    input  logic [23:0]           cfg_rem_qpn,
    input  logic [15:0]           cfg_p_key,
    input  logic [23:0]           cfg_start_psn,
    input  logic                  cfg_psn_load,
    input  logic [COALESCE_W-1:0] cfg_ack_coalesce,
    output logic [31:0]           stat_ack_count,
    output logic [31:0]           stat_nak_count,
    output logic [31:0]           stat_dup_count
);
    localparam logic [7:0] SYN_ACK = 8'h1F;
    localparam logic [7:0] SYN_NAK = 8'h60;
    localparam logic [7:0] OP_ACK  = 8'h11;

    logic [23:0]           r_epsn, r_msn;
    logic [COALESCE_W-1:0] r_coal_cnt;
    logic                  r_nak_latch;

    logic                  r_pend_vld, r_pend_nak;
    logic [23:0]           r_pend_psn, r_pend_msn;

    logic                  r_out_vld;
    logic [7:0]            r_out_op, r_out_syn;
    logic [15:0]           r_out_pkey;
    logic [23:0]           r_out_psn, r_out_msn, r_out_dqp;

    logic                  w_hit, w_inord, w_ooo, w_dup, w_last;
    logic [23:0]           w_d, w_msn_nxt, w_evt_psn, w_evt_msn;
    logic [COALESCE_W-1:0] w_cnt_inc;
    logic                  w_coal_hit, w_ack_io, w_nak, w_evt;
    logic                  w_out_load, w_pend_wr, w_hs;

    // RC SEND/WRITE LAST and ONLY opcodes (with and without immediate) complete a message
    always_comb begin
        w_last = 1'b0;
        case (s_roce_rx_bth_op_code)
            8'h02, 8'h03, 8'h04, 8'h05,
            8'h08, 8'h09, 8'h0A, 8'h0B: w_last = 1'b1;
            default:                    w_last = 1'b0;
        endcase
    end

    always_comb begin
        w_hit      = s_roce_rx_bth_valid && (s_roce_rx_bth_dest_qp == monitor_loc_qpn) && !cfg_psn_load;
        w_d        = s_roce_rx_bth_psn - r_epsn;
        w_inord    = w_hit && (w_d == 24'd0);
        w_ooo      = w_hit && (w_d != 24'd0) && !w_d[23];
        w_dup      = w_hit && w_d[23];
        w_msn_nxt  = r_msn + {23'd0, w_last};
        w_cnt_inc  = r_coal_cnt + {{(COALESCE_W-1){1'b0}}, 1'b1};
        w_coal_hit = (cfg_ack_coalesce != '0) && (w_cnt_inc == cfg_ack_coalesce);
        w_ack_io   = w_inord && (s_roce_rx_bth_ack_req || w_coal_hit);
        w_nak      = w_ooo && !r_nak_latch;
        w_evt      = w_ack_io || w_nak || w_dup;
        w_evt_psn  = w_ack_io ? s_roce_rx_bth_psn : (w_nak ? r_epsn : r_epsn - 24'd1);
        w_evt_msn  = w_ack_io ? w_msn_nxt : r_msn;
        w_hs       = r_out_vld && m_roce_tx_bth_ready;
        w_out_load = r_pend_vld && (!r_out_vld || m_roce_tx_bth_ready);
        // a pending NAK is only displaced by a newer NAK or once it has moved to the output
        w_pend_wr  = w_evt && (!r_pend_vld || w_out_load || !r_pend_nak || w_nak);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_epsn      <= '0;
            r_msn       <= '0;
            r_coal_cnt  <= '0;
            r_nak_latch <= 1'b0;
        end else if (cfg_psn_load) begin
            r_epsn      <= cfg_start_psn;
            r_msn       <= '0;
            r_coal_cnt  <= '0;
            r_nak_latch <= 1'b0;
        end else if (w_inord) begin
            r_epsn      <= r_epsn + 24'd1;
            r_msn       <= w_msn_nxt;
            r_nak_latch <= 1'b0;
            r_coal_cnt  <= w_ack_io ? '0 : w_cnt_inc;
        end else if (w_nak) begin
            r_nak_latch <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_vld <= 1'b0;
            r_pend_nak <= 1'b0;
            r_pend_psn <= '0;
            r_pend_msn <= '0;
        end else if (w_pend_wr) begin
            r_pend_vld <= 1'b1;
            r_pend_nak <= w_nak;
            r_pend_psn <= w_evt_psn;
            r_pend_msn <= w_evt_msn;
        end else if (w_out_load) begin
            r_pend_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_vld  <= 1'b0;
            r_out_op   <= '0;
            r_out_syn  <= '0;
            r_out_pkey <= '0;
            r_out_psn  <= '0;
            r_out_msn  <= '0;
            r_out_dqp  <= '0;
        end else if (w_out_load) begin
            r_out_vld  <= 1'b1;
            r_out_op   <= OP_ACK;
            r_out_syn  <= r_pend_nak ? SYN_NAK : SYN_ACK;
            r_out_pkey <= cfg_p_key;
            r_out_psn  <= r_pend_psn;
            r_out_msn  <= r_pend_msn;
            r_out_dqp  <= cfg_rem_qpn;
        end else if (w_hs) begin
            r_out_vld  <= 1'b0;
        end
    end

    assign m_roce_tx_bth_valid     = r_out_vld;
    assign m_roce_tx_bth_op_code   = r_out_op;
    assign m_roce_tx_bth_p_key     = r_out_pkey;
    assign m_roce_tx_bth_psn       = r_out_psn;
    assign m_roce_tx_bth_dest_qp   = r_out_dqp;
    assign m_roce_tx_bth_ack_req   = 1'b0;
    assign m_roce_tx_aeth_syndrome = r_out_syn;
    assign m_roce_tx_aeth_msn      = r_out_msn;

`ifdef ROCE_ACK_STATS_EN
    logic [31:0] r_ack_cnt, r_nak_cnt, r_dup_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack_cnt <= '0;
            r_nak_cnt <= '0;
            r_dup_cnt <= '0;
        end else begin
            if (w_hs && (r_out_syn == SYN_ACK) && (r_ack_cnt != 32'hFFFF_FFFF))
                r_ack_cnt <= r_ack_cnt + 32'd1;
            if (w_hs && (r_out_syn == SYN_NAK) && (r_nak_cnt != 32'hFFFF_FFFF))
                r_nak_cnt <= r_nak_cnt + 32'd1;
            if (w_dup && (r_dup_cnt != 32'hFFFF_FFFF))
                r_dup_cnt <= r_dup_cnt + 32'd1;
        end
    end

    assign stat_ack_count = r_ack_cnt;
    assign stat_nak_count = r_nak_cnt;
    assign stat_dup_count = r_dup_cnt;
`else
    assign stat_ack_count = '0;
    assign stat_nak_count = '0;
    assign stat_dup_count = '0;
`endif
endmodule
